// File: rtl/adc_rx_pkg.sv
// Shared constants and state encoding for the serial ADC receiver.
package adc_rx_pkg;

    localparam int DEF_DIV   = 4;
    localparam int DEF_GAP   = 0;
    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        S_FRAME = 1'b0,
        S_GAP   = 1'b1
    } state_t;

    // Counter width for a count range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Serial clock divider: clk_div toggles every DIV clk_in cycles; rise_stb/fall_stb
// are high in the clk_in cycle whose edge makes clk_div rise/fall.
module adc_clk_div
    import adc_rx_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk_div,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int              CW       = cnt_width(DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap     = (div_cnt == CNT_LAST);
    assign rise_stb = wrap & ~clk_div;
    assign fall_stb = wrap &  clk_div;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_rx.sv
// Serial ADC receiver: frames cs_n, samples Din on clk_div rises, publishes words on Dout.
// Define ADC_MSB_FIRST_EN to assemble MSB first; default assembly is LSB first.
module adc_rx
    import adc_rx_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int GAP   = DEF_GAP,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             Din,
    output logic             clk_div,
    output logic [WIDTH-1:0] Dout,
    output logic             cs_n,
    output logic             data_valid
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam int            GW       = cnt_width(GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] word_next;
    logic [BW-1:0]    bit_pos;
    logic             rise_stb;
    logic             fall_stb;
    logic             unused_fall;

    adc_clk_div #(.DIV(DIV)) u_div (
        .clk_in   (clk_in),
        .reset    (reset),
        .clk_div  (clk_div),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Capture is rise-only; the fall strobe has no consumer here.
    assign unused_fall = fall_stb;

`ifdef ADC_MSB_FIRST_EN
    assign bit_pos = BIT_LAST - bit_cnt;
`else
    assign bit_pos = bit_cnt;
`endif

    // Shift register with the current Din merged in; on the last bit this is the full word.
    always_comb begin
        word_next          = shift;
        word_next[bit_pos] = Din;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= S_FRAME;
            cs_n       <= 1'b1;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shift      <= '0;
            Dout       <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                S_FRAME: begin
                    if (cs_n) begin
                        cs_n <= 1'b0;
                    end else if (rise_stb) begin
                        shift <= word_next;
                        if (bit_cnt == BIT_LAST) begin
                            Dout       <= word_next;
                            data_valid <= 1'b1;
                            bit_cnt    <= '0;
                            if (GAP > 0) begin
                                cs_n    <= 1'b1;
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // cs_n drops on the GAP-th rise so the next rise samples bit 0.
                    if (rise_stb) begin
                        if (gap_cnt == GAP_LAST) begin
                            cs_n    <= 1'b0;
                            gap_cnt <= '0;
                            state   <= S_FRAME;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_rx.sv
// Bench for adc_rx: one GAP=0 and one GAP=2 instance share clock, reset and Din.
module tb_adc_rx;

    localparam int DIV  = 4;
    localparam int GAP2 = 2;
`ifdef ADC_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    bit         sel;
    logic       div0, cs0, dv0, div2, cs2, dv2;
    logic [7:0] dout0, dout2;
    logic       m_div, m_cs, m_dv;
    logic [7:0] m_dout;

    int         checks   = 0;
    int         failures = 0;
    int         cyc;
    logic [7:0] exp_q[$];
    logic [7:0] last_word;

    always #5 clk = ~clk;

    adc_rx #(.DIV(DIV), .GAP(0), .WIDTH(8)) u0 (
        .clk_in(clk), .reset(rst), .Din(din),
        .clk_div(div0), .Dout(dout0), .cs_n(cs0), .data_valid(dv0)
    );

    adc_rx #(.DIV(DIV), .GAP(GAP2), .WIDTH(8)) u2 (
        .clk_in(clk), .reset(rst), .Din(din),
        .clk_div(div2), .Dout(dout2), .cs_n(cs2), .data_valid(dv2)
    );

    assign m_div  = sel ? div2  : div0;
    assign m_cs   = sel ? cs2   : cs0;
    assign m_dv   = sel ? dv2   : dv0;
    assign m_dout = sel ? dout2 : dout0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: divider period, valid pulses against the expected queue, cs_n high time.
    logic prev_div, prev_dv, seen_low;
    int   last_tog, hi_cnt;
    always @(negedge clk) begin
        if (rst) begin
            prev_div = 1'b0; prev_dv = 1'b0; seen_low = 1'b0;
            last_tog = 0;    hi_cnt  = 0;
        end else begin
            if (m_div !== prev_div) begin
                chk("div_half_period", cyc - last_tog, DIV);
                last_tog = cyc;
                prev_div = m_div;
            end
            if (m_dv === 1'b1) begin
                chk("valid_one_cycle", prev_dv, 1'b0);
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL extra_valid observed=pulse Dout=0x%0h expected=no pulse", m_dout);
                end
                if (exp_q.size() != 0) chk("dout_word", m_dout, exp_q.pop_front());
            end
            prev_dv = m_dv;
            if (m_cs === 1'b0) begin
                if (seen_low && hi_cnt != 0) chk("cs_n_gap_len", hi_cnt, sel ? 2 * GAP2 * DIV : 0);
                seen_low = 1'b1;
                hi_cnt   = 0;
            end else if (seen_low) begin
                hi_cnt++;
            end
        end
    end

    task automatic wait_div(input logic level);
        logic prev;
        prev = m_div;
        for (int n = 0; n < 64; n++) begin
            @(posedge clk); #1;
            if (prev === ~level && m_div === level) return;
            prev = m_div;
        end
        checks++;
        failures++;
        $error("FAIL div_edge_timeout observed=no clk_div edge expected=edge within 64 cycles");
    endtask

    task automatic send_bit(input logic b, input bit first);
        if (!first) wait_div(1'b0);
        din = b;
    endtask

    function automatic logic ser_bit(input logic [7:0] w, input int i);
        return MSB_FIRST ? w[7-i] : w[i];
    endfunction

    task automatic send_word(input logic [7:0] w, input bit skip_first);
        for (int i = (skip_first ? 1 : 0); i < 8; i++) send_bit(ser_bit(w, i), 1'b0);
        last_word = w;
    endtask

    task automatic release_rst(input logic first_bit);
        @(posedge clk); #1;
        rst = 1'b0;
        din = first_bit;
        @(posedge clk); #1;
        chk("cs_n_first_edge", m_cs, 1'b0);
        chk("dout_after_reset", m_dout, 8'h00);
    endtask

    task automatic drain();
        wait_div(1'b0);
        wait_div(1'b0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [7:0] p;
        rst = 1'b1; din = 1'b0; sel = 1'b0; last_word = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_clk_div0", div0, 1'b0);  chk("rst_dout0", dout0, 8'h00);
        chk("rst_cs_n0", cs0, 1'b1);      chk("rst_valid0", dv0, 1'b0);
        chk("rst_clk_div2", div2, 1'b0);  chk("rst_dout2", dout2, 8'h00);
        chk("rst_cs_n2", cs2, 1'b1);      chk("rst_valid2", dv2, 1'b0);

        // GAP=0: 0xAA, 0x55, then random words back to back.
        exp_q.push_back(8'hAA);
        release_rst(ser_bit(8'hAA, 0));
        send_word(8'hAA, 1'b1);
        exp_q.push_back(8'h55);
        send_word(8'h55, 1'b0);
        for (int k = 0; k < 4; k++) begin
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            send_word(w, 1'b0);
        end

        // Four bits of a partial word, then reset mid-frame.
        p = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) send_bit(ser_bit(p, i), 1'b0);
        wait_div(1'b1);
        chk("partial_keeps_dout", m_dout, last_word);
        chk("partial_no_valid", m_dv, 1'b0);
        chk("partial_queue_empty", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        chk("midrst_dout", m_dout, 8'h00);
        chk("midrst_cs_n", m_cs, 1'b1);
        chk("midrst_clk_div", m_div, 1'b0);
        repeat (3) @(posedge clk);
        exp_q.push_back(8'h3C);
        release_rst(ser_bit(8'h3C, 0));
        send_word(8'h3C, 1'b1);
        drain();

        // Bit order: first sampled bit 1, the rest 0.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        exp_q.push_back(MSB_FIRST ? 8'h80 : 8'h01);
        release_rst(1'b1);
        for (int i = 1; i < 8; i++) send_bit(1'b0, 1'b0);
        drain();

        // GAP=2 instance: random words with random Din during the gap.
        #1 rst = 1'b1;
        sel = 1'b1;
        repeat (3) @(posedge clk);
        w = 8'($urandom_range(0, 255));
        exp_q.push_back(w);
        release_rst(ser_bit(w, 0));
        send_word(w, 1'b1);
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < GAP2; g++) send_bit(1'($urandom_range(0, 1)), 1'b0);
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            send_word(w, 1'b0);
        end
        drain();
        chk("gap_dout_holds", m_dout, last_word);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
